// File: rtl/aska_spi_host.sv
// SPI mode 0 host that ships the ASKA configuration words (conf0, conf1, ele1, ele2) as framed transfers.
// Optional build macro ASKA_SPI_PARITY_EN appends an odd-parity bit after the data LSB of every frame.
module aska_spi_host #(
    parameter int M       = 33,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   word_mask,
    input  logic [M-1:0] conf0,
    input  logic [M-1:0] conf1,
    input  logic [M-1:0] ele1,
    input  logic [M-1:0] ele2,
    output logic         SPI_CS,
    output logic         SPI_Clk,
    output logic         SPI_MOSI,
    output logic         busy,
    output logic         done
);

`ifdef ASKA_SPI_PARITY_EN
    localparam int NB = M + 3;
`else
    localparam int NB = M + 2;
`endif
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(M + 3);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    // Lowest selected address at or above 'from'; MSB of the result flags a hit.
    function automatic logic [2:0] find_next(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] build_frame(input logic [1:0] addr, input logic [M-1:0] word);
`ifdef ASKA_SPI_PARITY_EN
        return {addr, word, ~(^{addr, word})};
`else
        return {addr, word};
`endif
    endfunction

    function automatic logic [M-1:0] pick_word(input logic [1:0] idx, input logic [M-1:0] w0,
                                               input logic [M-1:0] w1, input logic [M-1:0] w2,
                                               input logic [M-1:0] w3);
        case (idx)
            2'd0:    return w0;
            2'd1:    return w1;
            2'd2:    return w2;
            2'd3:    return w3;
            default: return w0;
        endcase
    endfunction

    logic [2:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [BW-1:0] bit_cnt_r;
    logic          gap_half_r;
    logic [1:0]    addr_r;
    logic [3:0]    mask_r;
    logic [M-1:0]  words_r [4];
    logic [NB-1:0] shift_r;
    logic          cs_r, sclk_r, mosi_r, busy_r, done_r;

    logic [2:0]    first_s, next_s;
    logic [NB-1:0] frame_first_s, frame_next_s;

    // Frame selection for the accepted request and for the frame following the current one.
    always_comb begin
        first_s       = find_next(word_mask, 3'd0);
        next_s        = find_next(mask_r, {1'b0, addr_r} + 3'd1);
        frame_first_s = build_frame(first_s[1:0], pick_word(first_s[1:0], conf0, conf1, ele1, ele2));
        frame_next_s  = build_frame(next_s[1:0], words_r[next_s[1:0]]);
    end

    // Transfer sequencer; pin values are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= '0;
            gap_half_r <= 1'b0;
            addr_r     <= 2'd0;
            mask_r     <= 4'd0;
            shift_r    <= '0;
            for (int i = 0; i < 4; i++) begin
                words_r[i] <= '0;
            end
            cs_r   <= 1'b1;
            sclk_r <= 1'b0;
            mosi_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        words_r[0] <= conf0;
                        words_r[1] <= conf1;
                        words_r[2] <= ele1;
                        words_r[3] <= ele2;
                        mask_r     <= word_mask;
                        if (first_s[2]) begin
                            addr_r    <= first_s[1:0];
                            shift_r   <= frame_first_s;
                            mosi_r    <= frame_first_s[NB-1];
                            cnt_r     <= '0;
                            bit_cnt_r <= '0;
                            cs_r      <= 1'b0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_LOW;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_FIN;
                        end
                    end
                end
                ST_LOW: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        sclk_r  <= 1'b1;
                        state_r <= ST_HIGH;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r  <= '0;
                        sclk_r <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= ST_HOLD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            shift_r   <= {shift_r[NB-2:0], 1'b0};
                            mosi_r    <= shift_r[NB-2];
                            state_r   <= ST_LOW;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r      <= '0;
                        gap_half_r <= 1'b0;
                        cs_r       <= 1'b1;
                        mosi_r     <= 1'b0;
                        state_r    <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                // The gap is two half-periods long, so the narrow counter runs through twice.
                ST_GAP: begin
                    if (cnt_r != CNT_LAST) begin
                        cnt_r <= cnt_r + CW'(1);
                    end else if (!gap_half_r) begin
                        cnt_r      <= '0;
                        gap_half_r <= 1'b1;
                    end else if (next_s[2]) begin
                        cnt_r     <= '0;
                        bit_cnt_r <= '0;
                        addr_r    <= next_s[1:0];
                        shift_r   <= frame_next_s;
                        mosi_r    <= frame_next_s[NB-1];
                        cs_r      <= 1'b0;
                        state_r   <= ST_LOW;
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cs_r    <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign SPI_CS   = cs_r;
    assign SPI_Clk  = sclk_r;
    assign SPI_MOSI = mosi_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_aska_spi_host.sv
// Self-checking bench for aska_spi_host: a slave-side capture model checked against frames and timing
// derived from the framing rules (address, MSB-first data, optional odd parity, F-cycle frames).
module tb_aska_spi_host;
    localparam int M = 33;
    localparam int D = 4;
`ifdef ASKA_SPI_PARITY_EN
    localparam int NB = M + 3;
`else
    localparam int NB = M + 2;
`endif
    localparam int F = NB * 2 * D + 3 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   word_mask = 4'd0;
    logic [M-1:0] conf0 = '0, conf1 = '0, ele1 = '0, ele2 = '0;
    logic         SPI_CS, SPI_Clk, SPI_MOSI, busy, done;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [63:0] frames[$];
    int          nbits[$];
    logic [63:0] cur_v;
    int          cur_n, since_rise, cs_falls, mosi_viol, per_viol;
    logic        prev_cs, prev_sclk, prev_mosi;

    aska_spi_host #(.M(M), .CLK_DIV(D)) dut (
        .clk(clk), .reset(rst), .start(start), .word_mask(word_mask),
        .conf0(conf0), .conf1(conf1), .ele1(ele1), .ele2(ele2),
        .SPI_CS(SPI_CS), .SPI_Clk(SPI_Clk), .SPI_MOSI(SPI_MOSI), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as the slave should see it: 2-bit address, MSB-first word, then odd parity if enabled.
    function automatic logic [63:0] exp_frame(input int a, input logic [M-1:0] w);
        logic [63:0] v;
        v = (64'(a) << M) | 64'(w);
`ifdef ASKA_SPI_PARITY_EN
        v = (v << 1) | 64'(($countones(v) % 2) == 0);
`endif
        return v;
    endfunction

    function automatic logic [M-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    // Slave model: capture MOSI on each SPI_Clk rise inside a CS-low window.
    task automatic sample();
        if (prev_cs && !SPI_CS) begin
            cs_falls++;
            cur_n = 0;
            cur_v = '0;
            since_rise = 0;
        end
        if (!SPI_CS && SPI_Clk && !prev_sclk) begin
            if (cur_n > 0 && since_rise != 2 * D) per_viol++;
            cur_v = {cur_v[62:0], SPI_MOSI};
            cur_n++;
            since_rise = 0;
        end
        if (SPI_Clk && prev_sclk && (SPI_MOSI !== prev_mosi)) mosi_viol++;
        if (!prev_cs && SPI_CS) begin
            frames.push_back(cur_v);
            nbits.push_back(cur_n);
        end
        since_rise++;
        prev_cs = SPI_CS;
        prev_sclk = SPI_Clk;
        prev_mosi = SPI_MOSI;
    endtask

    task automatic run_xfer(input string tag, input logic [3:0] mask, input logic [M-1:0] w0,
                            input logic [M-1:0] w1, input logic [M-1:0] w2, input logic [M-1:0] w3,
                            input bit poke);
        int n, cyc, first_busy, last_busy, busy_n, done_cyc, done_n, k;
        logic cs1;
        logic [M-1:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        n = $countones(mask);
        frames.delete();
        nbits.delete();
        cs_falls = 0; mosi_viol = 0; per_viol = 0; cur_n = 0; cur_v = '0; since_rise = 0;
        prev_cs = SPI_CS; prev_sclk = SPI_Clk; prev_mosi = SPI_MOSI;
        first_busy = -1; last_busy = -1; busy_n = 0; done_cyc = -1; done_n = 0; cs1 = 1'b1;
        @(negedge clk);
        start = 1'b1; word_mask = mask;
        conf0 = w0; conf1 = w1; ele1 = w2; ele2 = w3;
        @(posedge clk);
        cyc = 0;
        while (cyc < n * F + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                conf0 = rnd_word(); conf1 = rnd_word(); ele1 = rnd_word(); ele2 = rnd_word();
                word_mask = 4'($urandom());
                cs1 = SPI_CS;
            end
            if (poke && cyc == 50) begin
                start = 1'b1; word_mask = 4'hF;
                conf0 = rnd_word(); conf1 = rnd_word(); ele1 = rnd_word(); ele2 = rnd_word();
            end
            if (poke && cyc == 51) start = 1'b0;
            sample();
            if (busy === 1'b1) begin
                busy_n++;
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end
            if (done === 1'b1) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(n * F + 1));
        check({tag, " done_pulses"}, 64'(done_n), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(n * F));
        check({tag, " cs_falls"}, 64'(cs_falls), 64'(n));
        check({tag, " frame_count"}, 64'(frames.size()), 64'(n));
        if (n > 0) begin
            check({tag, " first_busy"}, 64'(first_busy), 64'd1);
            check({tag, " last_busy"}, 64'(last_busy), 64'(n * F));
            check({tag, " cs_cycle1"}, 64'(cs1), 64'd0);
            check({tag, " mosi_stable"}, 64'(mosi_viol), 64'd0);
            check({tag, " clk_period"}, 64'(per_viol), 64'd0);
        end
        k = 0;
        for (int a = 0; a < 4; a++) begin
            if (mask[a] && k < frames.size()) begin
                check($sformatf("%s frame%0d", tag, a), frames[k], exp_frame(a, w[a]));
                check($sformatf("%s bits%0d", tag, a), 64'(nbits[k]), 64'(NB));
                k++;
            end
        end
    endtask

    initial begin
        logic [3:0] m;
        #1 rst = 1'b1;
        #2;
        check("reset CS", 64'(SPI_CS), 64'd1);
        check("reset Clk", 64'(SPI_Clk), 64'd0);
        check("reset MOSI", 64'(SPI_MOSI), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_xfer("all4", 4'b1111, rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b0);
        run_xfer("ele1", 4'b0100, rnd_word(), rnd_word(), 33'h1_2345_6789, rnd_word(), 1'b0);
        run_xfer("none", 4'b0000, rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b0);
        run_xfer("conf0_zero", 4'b0001, '0, rnd_word(), rnd_word(), rnd_word(), 1'b0);
        run_xfer("restart", 4'b1011, rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b1);
        run_xfer("ones", 4'b1010, '1, '1, '1, '1, 1'b0);

        // Reset mid-frame of conf1: pins and busy must drop without waiting for a clock edge.
        @(negedge clk);
        start = 1'b1; word_mask = 4'b0010; conf1 = rnd_word();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_reset busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("midreset CS", 64'(SPI_CS), 64'd1);
        check("midreset Clk", 64'(SPI_Clk), 64'd0);
        check("midreset MOSI", 64'(SPI_MOSI), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_xfer("after_reset", 4'b0010, rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'b0);

        for (int i = 0; i < 5; i++) begin
            m = 4'($urandom_range(1, 15));
            run_xfer($sformatf("rand%0d", i), m, rnd_word(), rnd_word(), rnd_word(), rnd_word(),
                     1'($urandom()));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
